// File: rtl/sqrt_pkg.sv
// Shared types and constants for the BCD conversion arbiter.
// The sequential engine constants are only consumed when BCD_SEQ_EN is defined.
package sqrt_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StHold = 2'd2
    } conv_state_e;

    localparam int unsigned BcdW     = 10;
    localparam int unsigned SeqIters = 5;
    localparam int unsigned PreShift = 3;

    // Full double-dabble of an 8-bit value; BCD digits end up in [17:8].
    function automatic logic [BcdW-1:0] bin_to_bcd(input logic [7:0] bin);
        logic [17:0] sr;
        sr = {10'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sr[11:8] >= 4'd5) begin
                sr[11:8] = sr[11:8] + 4'd3;
            end
            if (sr[15:12] >= 4'd5) begin
                sr[15:12] = sr[15:12] + 4'd3;
            end
            sr = sr << 1;
        end
        return sr[17:8];
    endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Registered shift-add-3 binary-to-BCD engine, one iteration per cycle.
// Compiled only when BCD_SEQ_EN is defined.
`ifdef BCD_SEQ_EN
module bcd_dabble_seq
    import sqrt_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [7:0]      bin,
    output logic            done,
    output logic [BcdW-1:0] bcd
);

    logic [17:0] sr_q;
    logic [17:0] sr_adj;
    logic [2:0]  cnt_q;
    logic        run_q;
    logic        done_q;

    always_comb begin
        sr_adj = sr_q;
        if (sr_adj[11:8] >= 4'd5) begin
            sr_adj[11:8] = sr_adj[11:8] + 4'd3;
        end
        if (sr_adj[15:12] >= 4'd5) begin
            sr_adj[15:12] = sr_adj[15:12] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (load) begin
            // The first three shifts can never need a correction, so skip them.
            sr_q   <= 18'(bin) << PreShift;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            sr_q  <= sr_adj << 1;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'(SeqIters - 1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done = done_q;
    assign bcd  = sr_q[17:8];

endmodule
`endif

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one 8-bit binary-to-BCD converter between NREQ requesters.
// Define BCD_SEQ_EN to use the multi-cycle shift-add-3 engine instead of the combinational one.
module bcd_conv_arbiter
    import sqrt_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BcdW-1:0]   out_bcd,
    output logic [IDW-1:0]    out_id,
    output logic              busy
);

    conv_state_e     state_q;
    logic [IDW-1:0]  last_grant_q;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  grant_idx;
    logic [7:0]      sel_data;
    logic            found;
    int unsigned     target;
    logic            accept;
    logic            conv_done;
    logic [BcdW-1:0] conv_bcd;

    // Search order starts just after the last winner; first valid requester wins.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        sel_data  = '0;
        found     = 1'b0;
        target    = 0;
        if (state_q == StIdle) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                target = (32'(last_grant_q) + k) % NREQ;
                for (int unsigned i = 0; i < NREQ; i++) begin
                    if (!found && (i == target) && req_valid[i]) begin
                        found        = 1'b1;
                        req_ready[i] = 1'b1;
                        grant_idx    = IDW'(i);
                        sel_data     = req_data[8*i +: 8];
                    end
                end
            end
        end
    end

    assign accept = |req_ready;
    assign busy   = (state_q != StIdle);

`ifdef BCD_SEQ_EN
    bcd_dabble_seq u_dabble (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .bin   (sel_data),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );
`else
    logic [7:0]      operand_q;
    logic            done_q;
    logic [BcdW-1:0] bcd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_q <= '0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            if (accept) begin
                operand_q <= sel_data;
            end
            // Single-cycle pulse on the first CONV cycle; FSM consumes it on the next edge.
            done_q <= (state_q == StConv) && !done_q;
            if (state_q == StConv) begin
                bcd_q <= bin_to_bcd(operand_q);
            end
        end
    end

    assign conv_done = done_q;
    assign conv_bcd  = bcd_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            out_valid    <= 1'b0;
            out_bcd      <= '0;
            out_id       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        id_q         <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= StConv;
                    end
                end
                StConv: begin
                    if (conv_done) begin
                        out_bcd   <= conv_bcd;
                        out_id    <= id_q;
                        out_valid <= 1'b1;
                        state_q   <= StHold;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
